// File: rtl/sweep_pkg.sv
// Shared types and sizing helpers for the truth-table sweeper.
package sweep_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} sweep_state_t;

  // Number of input vectors for an n-input function.
  function automatic int NVEC(input int n);
    return 1 << n;
  endfunction

  // Width of a counter that must hold values up to settle.
  function automatic int cnt_width(input int settle);
    return (settle < 1) ? 1 : $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/settle_counter.sv
// Per-vector settle timer: counts while enabled, flags the last settle cycle.
module settle_counter
  import sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 8,
  parameter int CNT_W         = cnt_width(SETTLE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)   cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CNT_W'(1);
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples its inputs from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks every input vector of a combinational FUT, lets it settle, and
// compares the sampled output against a golden truth table.
module truth_table_sweeper
  import sweep_pkg::*;
#(
  parameter int                    N_IN          = 4,
  parameter int                    SETTLE_CYCLES = 8,
  parameter logic [NVEC(N_IN)-1:0] EXPECTED      = 16'h7FFF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_vld
);

  localparam logic [N_IN-1:0] LAST_VEC = '1;

  sweep_state_t state_q, state_d;

  logic [N_IN-1:0] vec_q, vec_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] ff_vec_q, ff_vec_d;
  logic            ff_vld_q, ff_vld_d;
  logic            settle_tc;

  wire idle_or_done = (state_q == IDLE) || (state_q == DONE);
  wire in_sweep     = (state_q == DRIVE) || (state_q == SAMPLE);
  wire start_sweep  = idle_or_done && start;
  wire abort_sweep  = in_sweep && abort;
  wire mismatch     = (dut_out != EXPECTED[vec_q]);

  settle_counter #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (state_q != DRIVE),
    .en_i    (state_q == DRIVE),
    .tc_o    (settle_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every variable written in a combinational block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (start) state_d = DRIVE;
      DRIVE:  if (abort) state_d = IDLE;
              else if (settle_tc) state_d = SAMPLE;
      SAMPLE: if (abort) state_d = IDLE;
              else if (vec_q == LAST_VEC) state_d = DONE;
              else state_d = DRIVE;
      DONE:   if (start) state_d = DRIVE;
      default: state_d = IDLE;
    endcase
  end

  // Abort leaves the partial error results visible but parks the FUT at 0.
  always_comb begin
    vec_d    = vec_q;
    err_d    = err_q;
    ff_vec_d = ff_vec_q;
    ff_vld_d = ff_vld_q;
    if (start_sweep) begin
      vec_d    = '0;
      err_d    = '0;
      ff_vec_d = '0;
      ff_vld_d = 1'b0;
    end else if (abort_sweep) begin
      vec_d = '0;
    end else if (state_q == SAMPLE) begin
      if (mismatch) begin
        err_d = err_q + (N_IN + 1)'(1);
        if (!ff_vld_q) begin
          ff_vec_d = vec_q;
          ff_vld_d = 1'b1;
        end
      end
      if (vec_q != LAST_VEC) vec_d = vec_q + N_IN'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q    <= '0;
      err_q    <= '0;
      ff_vec_q <= '0;
      ff_vld_q <= 1'b0;
    end else begin
      vec_q    <= vec_d;
      err_q    <= err_d;
      ff_vec_q <= ff_vec_d;
      ff_vld_q <= ff_vld_d;
    end
  end

  always_comb begin
    dut_in         = vec_q;
    busy           = in_sweep;
    done           = (state_q == DONE);
    pass           = (state_q == DONE) && (err_q == '0);
    err_count      = err_q;
    first_fail_vec = ff_vec_q;
    first_fail_vld = ff_vld_q;
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: a 4-input NAND model with per-vector fault injection as FUT.
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] dut_in;
  logic       dut_out;
  logic       busy, done, pass, first_fail_vld;
  logic [4:0] err_count;
  logic [3:0] first_fail_vec;
  logic [15:0] fault_mask = '0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // FUT: 4-input NAND (truth table 16'h7FFF) with selectable output flips.
  assign dut_out = ~(&dut_in) ^ fault_mask[dut_in];

  truth_table_sweeper #(
    .N_IN          (4),
    .SETTLE_CYCLES (8),
    .EXPECTED      (16'h7FFF)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .dut_in         (dut_in),
    .dut_out        (dut_out),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_fail_vec (first_fail_vec),
    .first_fail_vld (first_fail_vld)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start is captured on the next edge (edge 0 of the sweep).
  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dut_in"}, 32'(dut_in), 32'd0);
    check({tag, "_busy"},   32'(busy), 32'd0);
    check({tag, "_done"},   32'(done), 32'd0);
    check({tag, "_pass"},   32'(pass), 32'd0);
    check({tag, "_err"},    32'(err_count), 32'd0);
    check({tag, "_ffvec"},  32'(first_fail_vec), 32'd0);
    check({tag, "_ffvld"},  32'(first_fail_vld), 32'd0);
  endtask

  // Called just after edge 0; runs to edge 144 and checks the results.
  task automatic finish_sweep(input string tag, input int exp_err,
                              input int exp_ffv, input int exp_vld);
    tick(143);
    check({tag, "_done_e143"}, 32'(done), 32'd0);
    tick(1);
    check({tag, "_done_e144"}, 32'(done), 32'd1);
    check({tag, "_busy"},      32'(busy), 32'd0);
    check({tag, "_pass"},      32'(pass), (exp_err == 0) ? 32'd1 : 32'd0);
    check({tag, "_err"},       32'(err_count), 32'(exp_err));
    check({tag, "_ffvec"},     32'(first_fail_vec), 32'(exp_ffv));
    check({tag, "_ffvld"},     32'(first_fail_vld), 32'(exp_vld));
  endtask

  initial begin
    #13;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick(2);
    check_all_zero("idle");

    // 1: clean sweep, dut_in steps every 9 edges
    pulse_start();
    check("t1_busy_e0", 32'(busy), 32'd1);
    check("t1_dut_in_e0", 32'(dut_in), 32'd0);
    for (int e = 1; e < 144; e++) begin
      tick(1);
      check("t1_dut_in", 32'(dut_in), 32'(e / 9));
    end
    tick(1);
    check("t1_done", 32'(done), 32'd1);
    check("t1_pass", 32'(pass), 32'd1);
    check("t1_err", 32'(err_count), 32'd0);
    check("t1_ffvld", 32'(first_fail_vld), 32'd0);
    check("t1_hold_dut_in", 32'(dut_in), 32'd15);
    tick(5);
    check("t1_done_hold", 32'(done), 32'd1);

    // 2: faults on vectors 5 and 12; restart from DONE drops done next edge
    fault_mask = 16'h1020;
    pulse_start();
    check("t2_done_drop", 32'(done), 32'd0);
    check("t2_busy", 32'(busy), 32'd1);
    finish_sweep("t2", 2, 5, 1);

    // 3: every vector fails, count reaches 16 without wrapping
    fault_mask = 16'hFFFF;
    pulse_start();
    finish_sweep("t3", 16, 0, 1);

    // 4: abort at edge 40 with a simultaneous start; abort must win
    fault_mask = 16'h0004;
    pulse_start();
    tick(39);
    check("t4_dut_in_e39", 32'(dut_in), 32'd4);
    abort = 1'b1;
    start = 1'b1;
    tick(1);
    abort = 1'b0;
    start = 1'b0;
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_done", 32'(done), 32'd0);
    check("t4_dut_in", 32'(dut_in), 32'd0);
    check("t4_err_kept", 32'(err_count), 32'd1);
    check("t4_ffvec_kept", 32'(first_fail_vec), 32'd2);
    check("t4_ffvld_kept", 32'(first_fail_vld), 32'd1);
    tick(3);
    check("t4_idle_busy", 32'(busy), 32'd0);
    fault_mask = '0;
    pulse_start();
    check("t4_rerun_err", 32'(err_count), 32'd0);
    check("t4_rerun_ffvld", 32'(first_fail_vld), 32'd0);
    check("t4_rerun_dut_in", 32'(dut_in), 32'd0);
    finish_sweep("t4r", 0, 0, 0);

    // 5: asynchronous reset between edges mid-sweep
    fault_mask = 16'h0002;
    pulse_start();
    tick(50);
    check("t5_err_pre", 32'(err_count), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("t5_async");
    #3;
    rst_n = 1'b1;
    fault_mask = '0;
    tick(2);
    check_all_zero("t5_post");
    pulse_start();
    finish_sweep("t5r", 0, 0, 0);

    // 6: start pulses while busy are ignored; timing unchanged
    pulse_start();
    tick(19);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("t6_dut_in_e20", 32'(dut_in), 32'd2);
    check("t6_busy_e20", 32'(busy), 32'd1);
    tick(80);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("t6_dut_in_e101", 32'(dut_in), 32'd11);
    tick(42);
    check("t6_done_e143", 32'(done), 32'd0);
    tick(1);
    check("t6_done_e144", 32'(done), 32'd1);
    check("t6_pass", 32'(pass), 32'd1);
    pulse_start();
    check("t6_restart_done", 32'(done), 32'd0);
    check("t6_restart_busy", 32'(busy), 32'd1);
    check("t6_restart_dut_in", 32'(dut_in), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
